// File: rtl/ahb_pkg.sv
// ahb_pkg -- shared AHB definitions for the interconnect slice.
//   HTRANS encodings, master ID constants used on HMASTER/HMASTER_DATA,
//   the arbiter grant-state type, and a small transfer-type helper.
//   AHB_ADDR_BITS remains a global macro so existing users see no change.

`ifndef AHB_ADDR_BITS
`define AHB_ADDR_BITS 32
`endif

package ahb_pkg;

  // HTRANS encodings
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  // Master IDs as presented on HMASTER / HMASTER_DATA
  localparam logic [1:0] MST_DEF = 2'd0;
  localparam logic [1:0] MST_M1  = 2'd1;
  localparam logic [1:0] MST_M2  = 2'd2;

  // Registered bus owner; codes match the master IDs, code 3 is unused.
  typedef enum logic [1:0] {
    GNT_DEF = 2'd0,
    GNT_M1  = 2'd1,
    GNT_M2  = 2'd2
  } grant_e;

  // True for transfer types that carry a real beat.
  function automatic logic htrans_active(input logic [1:0] htrans);
    return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahb_rr_pick.sv
// ahb_rr_pick -- combinational two-requester round-robin chooser.
//   req_i[0]    : M1 requesting
//   req_i[1]    : M2 requesting
//   ptr_i       : priority pointer (0 = M1 favoured, 1 = M2 favoured)
//   winner_o    : master ID chosen (MST_DEF when nobody requests)
//   ptr_next_o  : pointer after this pick; moves to the master that did not
//                 win, and is unchanged when the default master is chosen.

module ahb_rr_pick
  import ahb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       ptr_i,
  output logic [1:0] winner_o,
  output logic       ptr_next_o
);

  always_comb begin
    winner_o   = MST_DEF;
    ptr_next_o = ptr_i;
    unique case (req_i)
      2'b01: begin
        winner_o   = MST_M1;
        ptr_next_o = 1'b1;
      end
      2'b10: begin
        winner_o   = MST_M2;
        ptr_next_o = 1'b0;
      end
      2'b11: begin
        if (ptr_i) begin
          winner_o   = MST_M2;
          ptr_next_o = 1'b0;
        end else begin
          winner_o   = MST_M1;
          ptr_next_o = 1'b1;
        end
      end
      default: begin
        winner_o   = MST_DEF;
        ptr_next_o = ptr_i;
      end
    endcase
  end

endmodule

// File: rtl/ahb_arbiter.sv
// ahb_arbiter -- bus-ownership arbiter for two AHB masters plus a default
// master. Issues registered grants, tracks address- and data-phase owners
// for the master-side muxes, honours locked transfers and limits a master's
// tenure with round-robin fairness.
//
// Ports:
//   HCLK, HRESET           clock, synchronous active-high reset
//   HBUSREQ_M1/M2          bus requests
//   HLOCK_M1/M2            locked-access requests
//   HTRANS, HREADY         muxed transfer type and slave ready
//   HGRANT_Default/M1/M2   one-hot grant outputs
//   HMASTER                address-phase owner (address/control mux select)
//   HMASTER_DATA           data-phase owner (write-data mux select)
//   HMASTLOCK              current address phase is locked

module ahb_arbiter
  import ahb_pkg::*;
#(
  parameter int unsigned MAX_TENURE = 16,
  parameter int unsigned CNT_BITS   = 5
) (
  input  logic       HCLK,
  input  logic       HRESET,
  input  logic       HBUSREQ_M1,
  input  logic       HBUSREQ_M2,
  input  logic       HLOCK_M1,
  input  logic       HLOCK_M2,
  input  logic [1:0] HTRANS,
  input  logic       HREADY,
  output logic       HGRANT_Default,
  output logic       HGRANT_M1,
  output logic       HGRANT_M2,
  output logic [1:0] HMASTER,
  output logic [1:0] HMASTER_DATA,
  output logic       HMASTLOCK
);

  localparam logic [CNT_BITS-1:0] TENURE_LAST = CNT_BITS'(MAX_TENURE - 1);
  localparam logic [CNT_BITS-1:0] TENURE_SAT  = CNT_BITS'(MAX_TENURE);

  grant_e              grant_q, grant_d;
  logic                ptr_q, ptr_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic [1:0]          hmaster_q, hmaster_d;
  logic [1:0]          hmdata_q, hmdata_d;
  logic                hmlock_q, hmlock_d;

  logic                own_req;
  logic                own_lock;
  logic [1:0]          grant_id;
  logic                permit;
  logic [1:0]          rr_winner;
  logic                rr_ptr_next;
  logic                beat;

  assign grant_id = grant_q;

  // Request/lock of whoever currently holds the grant.
  always_comb begin
    own_req  = 1'b0;
    own_lock = 1'b0;
    unique case (grant_q)
      GNT_M1: begin
        own_req  = HBUSREQ_M1;
        own_lock = HLOCK_M1;
      end
      GNT_M2: begin
        own_req  = HBUSREQ_M2;
        own_lock = HLOCK_M2;
      end
      default: begin
        own_req  = 1'b0;
        own_lock = 1'b0;
      end
    endcase
  end

  // A locked, still-requesting owner is never preempted; otherwise the bus
  // is released when the owner lets go or its tenure is used up.
  always_comb begin
    permit = HREADY
           && !(own_lock && own_req)
           && ((grant_q == GNT_DEF) || !own_req || (cnt_q >= TENURE_LAST));
  end

  ahb_rr_pick u_rr_pick (
    .req_i      ({HBUSREQ_M2, HBUSREQ_M1}),
    .ptr_i      (ptr_q),
    .winner_o   (rr_winner),
    .ptr_next_o (rr_ptr_next)
  );

  // A beat counts only once the address phase is actually driven by the
  // grant holder, so the hand-over cycle is not charged to the new owner.
  assign beat = HREADY && htrans_active(HTRANS) && (hmaster_q == grant_id);

  always_comb begin
    grant_d = grant_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    if (permit) begin
      grant_d = grant_e'(rr_winner);
      ptr_d   = rr_ptr_next;
      cnt_d   = '0;
    end else if (beat && (cnt_q != TENURE_SAT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_comb begin
    hmaster_d = hmaster_q;
    hmdata_d  = hmdata_q;
    hmlock_d  = hmlock_q;
    if (HREADY) begin
      hmaster_d = grant_id;
      hmdata_d  = hmaster_q;
      hmlock_d  = own_lock;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      grant_q   <= GNT_DEF;
      ptr_q     <= 1'b0;
      cnt_q     <= '0;
      hmaster_q <= MST_DEF;
      hmdata_q  <= MST_DEF;
      hmlock_q  <= 1'b0;
    end else begin
      grant_q   <= grant_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      hmaster_q <= hmaster_d;
      hmdata_q  <= hmdata_d;
      hmlock_q  <= hmlock_d;
    end
  end

  assign HGRANT_Default = (grant_q == GNT_DEF);
  assign HGRANT_M1      = (grant_q == GNT_M1);
  assign HGRANT_M2      = (grant_q == GNT_M2);
  assign HMASTER        = hmaster_q;
  assign HMASTER_DATA   = hmdata_q;
  assign HMASTLOCK      = hmlock_q;

endmodule

// File: tb/tb_ahb_arbiter.sv
module tb_ahb_arbiter;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] NSQ  = 2'b10;
  localparam logic [1:0] SQ   = 2'b11;

  logic       HCLK = 1'b0;
  logic       HRESET;
  logic       HBUSREQ_M1, HBUSREQ_M2, HLOCK_M1, HLOCK_M2;
  logic [1:0] HTRANS;
  logic       HREADY;
  logic       HGRANT_Default, HGRANT_M1, HGRANT_M2;
  logic [1:0] HMASTER, HMASTER_DATA;
  logic       HMASTLOCK;

  always #5 HCLK = ~HCLK;

  ahb_arbiter #(.MAX_TENURE(16), .CNT_BITS(5)) dut (
    .HCLK           (HCLK),
    .HRESET         (HRESET),
    .HBUSREQ_M1     (HBUSREQ_M1),
    .HBUSREQ_M2     (HBUSREQ_M2),
    .HLOCK_M1       (HLOCK_M1),
    .HLOCK_M2       (HLOCK_M2),
    .HTRANS         (HTRANS),
    .HREADY         (HREADY),
    .HGRANT_Default (HGRANT_Default),
    .HGRANT_M1      (HGRANT_M1),
    .HGRANT_M2      (HGRANT_M2),
    .HMASTER        (HMASTER),
    .HMASTER_DATA   (HMASTER_DATA),
    .HMASTLOCK      (HMASTLOCK)
  );

  // Expected {gdef, gm1, gm2, HMASTER, HMASTER_DATA, HMASTLOCK} after an edge.
  typedef struct {
    logic [7:0] v;
    string      nm;
  } exp_t;

  exp_t sb_q[$];
  logic done = 1'b0;
  int   checks = 0;
  int   failures = 0;

  // Drive one cycle's inputs at the falling edge (n times) and queue the
  // outputs expected just after the following rising edge.
  task automatic step(input int n,
                      input logic r1, input logic r2,
                      input logic l1, input logic l2,
                      input logic [1:0] tr, input logic rdy, input logic rst,
                      input logic [1:0] eg, input logic [1:0] ehm,
                      input logic [1:0] ehmd, input logic elk,
                      input string nm);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(negedge HCLK);
      HBUSREQ_M1 = r1;
      HBUSREQ_M2 = r2;
      HLOCK_M1   = l1;
      HLOCK_M2   = l2;
      HTRANS     = tr;
      HREADY     = rdy;
      HRESET     = rst;
      e.v  = {(eg == 2'd0), (eg == 2'd1), (eg == 2'd2), ehm, ehmd, elk};
      e.nm = nm;
      sb_q.push_back(e);
    end
  endtask

  initial begin
    HRESET = 1'b1; HBUSREQ_M1 = 1'b0; HBUSREQ_M2 = 1'b0;
    HLOCK_M1 = 1'b0; HLOCK_M2 = 1'b0; HTRANS = IDLE; HREADY = 1'b1;

    //    n  r1 r2 l1 l2 tr    rdy rst  g  hm hmd lk
    step( 2, 0, 0, 0, 0, IDLE, 1, 1,   0, 0, 0, 0, "reset");
    step( 5, 0, 0, 0, 0, IDLE, 1, 0,   0, 0, 0, 0, "idle_default");
    step( 1, 1, 0, 0, 0, IDLE, 1, 0,   1, 0, 0, 0, "m1_grant");
    step( 1, 1, 0, 0, 0, IDLE, 1, 0,   1, 1, 0, 0, "m1_hmaster");
    step( 1, 1, 0, 0, 0, IDLE, 1, 0,   1, 1, 1, 0, "m1_hmdata");
    // both requesting: 16 counted beats each
    step( 1, 1, 1, 0, 0, NSQ,  1, 0,   1, 1, 1, 0, "m1_tenure");
    step(14, 1, 1, 0, 0, SQ,   1, 0,   1, 1, 1, 0, "m1_tenure");
    step( 1, 1, 1, 0, 0, SQ,   1, 0,   2, 1, 1, 0, "m1_expire");
    step( 1, 1, 1, 0, 0, NSQ,  1, 0,   2, 2, 1, 0, "m2_hmaster");
    step(15, 1, 1, 0, 0, SQ,   1, 0,   2, 2, 2, 0, "m2_tenure");
    step( 1, 1, 1, 0, 0, SQ,   1, 0,   1, 2, 2, 0, "m2_expire");
    step( 1, 1, 1, 0, 0, NSQ,  1, 0,   1, 1, 2, 0, "m1_back_hm");
    step( 1, 1, 1, 0, 0, SQ,   1, 0,   1, 1, 1, 0, "m1_back_hmd");
    // locked M2 holds through 40 beats of M1 requesting
    step( 1, 0, 1, 0, 1, NSQ,  1, 0,   2, 1, 1, 0, "lock_grant");
    step( 1, 1, 1, 0, 1, SQ,   1, 0,   2, 2, 1, 1, "lock_hmaster");
    step(39, 1, 1, 0, 1, SQ,   1, 0,   2, 2, 2, 1, "lock_hold");
    step( 1, 1, 1, 0, 0, SQ,   1, 0,   1, 2, 2, 0, "unlock_regrant");
    step( 1, 1, 1, 0, 0, NSQ,  1, 0,   1, 1, 2, 0, "unlock_hmaster");
    // wait states freeze everything
    step( 3, 0, 1, 0, 0, SQ,   0, 0,   1, 1, 2, 0, "stall_hold");
    step( 1, 0, 1, 0, 0, SQ,   1, 0,   2, 1, 1, 0, "stall_release");
    step( 1, 0, 1, 0, 0, NSQ,  1, 0,   2, 2, 1, 0, "stall_after");
    step( 1, 0, 1, 0, 1, SQ,   1, 0,   2, 2, 2, 1, "m2_locked");
    // reset in the middle of M2's burst
    step( 1, 0, 1, 0, 1, SQ,   1, 1,   0, 0, 0, 0, "reset_midburst");
    step( 1, 1, 1, 0, 0, NSQ,  1, 0,   1, 0, 0, 0, "ptr_reset_m1");
    // tenure expiry with nobody else waiting: re-grant and fresh count
    step( 1, 1, 0, 0, 0, NSQ,  1, 0,   1, 1, 0, 0, "solo_hmaster");
    step(15, 1, 0, 0, 0, SQ,   1, 0,   1, 1, 1, 0, "solo_tenure");
    step( 1, 1, 0, 0, 0, SQ,   1, 0,   1, 1, 1, 0, "solo_regrant");
    step(15, 1, 1, 0, 0, SQ,   1, 0,   1, 1, 1, 0, "regrant_cleared");
    step( 1, 1, 1, 0, 0, SQ,   1, 0,   2, 1, 1, 0, "regrant_expire");
    done = 1'b1;
  end

  // Monitor: pop one expectation per rising edge and compare.
  initial begin : monitor
    exp_t       e;
    logic [7:0] act;
    int         cyc;
    cyc = 0;
    forever begin
      @(posedge HCLK);
      #1;
      cyc++;
      if (sb_q.size() != 0) begin
        e   = sb_q.pop_front();
        act = {HGRANT_Default, HGRANT_M1, HGRANT_M2, HMASTER, HMASTER_DATA, HMASTLOCK};
        checks++;
        if (act !== e.v) begin
          failures++;
          $display("FAIL %s: got gnt(def,m1,m2)/hm/hmd/lk=%b required %b at cycle %0d",
                   e.nm, act, e.v, cyc);
        end
      end else if (done) begin
        break;
      end
      if (cyc > 2000) begin
        failures++;
        $display("FAIL timeout: got %0d pending expectations required 0", sb_q.size());
        break;
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ahb_arbiter.md
Name: ahb_arbiter

Overview:
Bus-ownership arbiter for the shared AHB interconnect. Two requesting masters (M1, M2) and a built-in default master share one address/data bus; the address decoder selects slaves downstream of it. The block issues grants, tracks address-phase and data-phase ownership for the master-side muxes, and enforces locked transfers and a bounded tenure with round-robin fairness.

Parameters:
MAX_TENURE, 16, maximum active beats (NONSEQ/SEQ with HREADY=1) a master may own the bus while the other master is requesting.
CNT_BITS, 5, width of the tenure counter; must satisfy 2^CNT_BITS > MAX_TENURE.

Ports:
HCLK  input  1  bus clock; all state updates on rising edge.
HRESET  input  1  synchronous, active-high reset.
HBUSREQ_M1  input  1  M1 bus request.
HBUSREQ_M2  input  1  M2 bus request.
HLOCK_M1  input  1  M1 requests locked access.
HLOCK_M2  input  1  M2 requests locked access.
HTRANS  input  2  transfer type on the muxed address bus (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ).
HREADY  input  1  muxed slave ready; phase-advance qualifier.
HGRANT_Default  output  1  default master granted.
HGRANT_M1  output  1  M1 granted.
HGRANT_M2  output  1  M2 granted.
HMASTER  output  2  address-phase owner (0 default, 1 M1, 2 M2); drives address/control mux select.
HMASTER_DATA  output  2  data-phase owner; drives write-data mux select.
HMASTLOCK  output  1  current address phase is locked.

Behaviour:
- Clock HCLK; reset HRESET is synchronous and active-high.
- Reset values: grant=default (HGRANT_Default=1, HGRANT_M1=HGRANT_M2=0), HMASTER=0, HMASTER_DATA=0, HMASTLOCK=0, tenure counter=0, round-robin pointer favours M1. Reset mid-burst discards all state identically.
- Grant is a registered 3-state owner (GNT_DEF, GNT_M1, GNT_M2); exactly one HGRANT_* high at all times; code 3 never produced.
- Rearbitration permitted in a cycle iff HREADY=1 AND NOT (owner's HLOCK=1 AND owner's HBUSREQ=1) AND (owner is default OR owner's HBUSREQ=0 OR tenure counter ≥ MAX_TENURE-1).
- When permitted, next owner: both requesting -> master not favoured by last grant (pointer flips to the loser on each grant to a requesting master); exactly one requesting -> that master; none -> default. Otherwise grant holds.
- Pointer: after a grant to M1, M2 has priority, and vice versa; a grant to default leaves the pointer unchanged.
- Grant lands one cycle after the permitting edge. HMASTER <= grant owner and HMASTLOCK <= owner's HLOCK on every edge with HREADY=1; both hold while HREADY=0.
- HMASTER_DATA <= HMASTER on every edge with HREADY=1; the data phase therefore lags address-phase ownership by one accepted transfer.
- Tenure counter: +1 on edges with HREADY=1, HTRANS ∈ {NONSEQ, SEQ}, and HMASTER == grant owner; cleared whenever the grant changes or the owner keeps the bus after a permitted rearbitration; saturates at MAX_TENURE.
- Locked owner keeps the grant regardless of tenure until it drops HLOCK or HBUSREQ.
- Wait states (HREADY=0) freeze grant, HMASTER, HMASTER_DATA, HMASTLOCK, and the counter.
- Tenure expiry with the other master idle: the owner is re-granted and the counter is cleared.

Decomposition:
- Shared ahb_pkg: HTRANS encodings (IDLE/BUSY/NONSEQ/SEQ), master ID constants (MST_DEF=0, MST_M1=1, MST_M2=2), grant-state enum; AHB_ADDR_BITS stays the existing macro.
- One natural sub-module, ahb_rr_pick: combinational two-requester round-robin chooser (req[1:0], pointer -> winner, pointer_next). Everything else stays in ahb_arbiter.

Test Plan:
- Reset then no requests for 5 cycles -> HGRANT_Default=1, HMASTER=0, HMASTER_DATA=0, HMASTLOCK=0 throughout.
- HBUSREQ_M1=1 at cycle 2, HREADY=1 -> HGRANT_M1=1 at cycle 3, HMASTER=1 at cycle 4, HMASTER_DATA=1 at cycle 5.
- Both request continuously, M1 owning, NONSEQ+SEQ beats with HREADY=1 -> grant moves to M2 after the 16th beat; M1 regains the grant after M2's 16th beat.
- M2 granted, HLOCK_M2=1, M1 requesting for 40 beats -> HGRANT_M2 held for all 40 beats with HMASTLOCK=1; HLOCK_M2 drops -> M1 granted the next permitted cycle.
- M1 owning, HREADY=0 for 3 cycles while M1 drops HBUSREQ and M2 requests -> no output changes during the stall; grant goes to M2 the first cycle after HREADY returns to 1.
- HRESET asserted mid-burst with M2 owning and HMASTER_DATA=2 -> next edge: HGRANT_Default=1, HMASTER=0, HMASTER_DATA=0, counter 0.
